// File: rtl/mem_stage.sv
// MEM stage: data-memory loads/stores over a req/ack bus, byte-lane alignment,
// LL/SC reservation tracking and bus locking. Stalls stages 1-4 while a transaction is in flight.
module mem_stage #(
    parameter int BITS      = 32,
    parameter int REG_WORDS = 32,
    parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 sel_mem_s4,
    input  logic                 mem_rw_s4,
    input  logic                 load_link_s4,
    input  logic                 check_link_s4,
    input  logic                 atomic_s4,
    input  logic                 rw_s4,
    input  logic [ADDR_LEFT:0]   waddr_s4,
    input  logic [BITS-1:0]      alu_out_s4,
    input  logic [BITS-1:0]      r2_data_s4,
    input  logic [3:0]           byte_en_s4,
    input  logic                 halt_s4,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 dmem_lock,
    output logic [BITS-1:0]      dmem_addr,
    output logic [BITS-1:0]      dmem_wdata,
    output logic [3:0]           dmem_be,
    input  logic                 dmem_ack,
    input  logic [BITS-1:0]      dmem_rdata,
    output logic                 mem_stall,
    output logic [BITS-1:0]      wb_data_s4,
    output logic                 wb_rw_s4,
    output logic [ADDR_LEFT:0]   wb_waddr_s4,
    output logic                 halted
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic            lock_q, lock_d;
    logic [BITS-1:0] addr_q, addr_d;
    logic [BITS-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            is_ll_q, is_ll_d;
    logic            is_sc_q, is_sc_d;
    logic            link_valid_q, link_valid_d;
    logic [BITS-1:0] link_addr_q, link_addr_d;
    logic [BITS-1:0] result_q, result_d;
    logic            halted_q, halted_d;

    logic [BITS-1:0] word_addr;
    logic            link_hit;
    logic            sc_fail;

    // Selected lanes moved down to bit 0, zero-extended.
    function automatic logic [BITS-1:0] load_lanes(input logic [BITS-1:0] d, input logic [3:0] be);
        logic [BITS-1:0] r;
        case (be)
            4'b1100: r = {16'h0, d[31:16]};
            4'b0011: r = {16'h0, d[15:0]};
            4'b1000: r = {24'h0, d[31:24]};
            4'b0100: r = {24'h0, d[23:16]};
            4'b0010: r = {24'h0, d[15:8]};
            4'b0001: r = {24'h0, d[7:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [BITS-1:0] store_lanes(input logic [BITS-1:0] d, input logic [3:0] be);
        logic [BITS-1:0] r;
        case (be)
            4'b1100, 4'b0011:                   r = {2{d[15:0]}};
            4'b1000, 4'b0100, 4'b0010, 4'b0001: r = {4{d[7:0]}};
            default:                            r = d;
        endcase
        return r;
    endfunction

    assign word_addr = {alu_out_s4[BITS-1:2], 2'b00};
    assign link_hit  = link_valid_q && (link_addr_q == word_addr);
    assign sc_fail   = mem_rw_s4 && check_link_s4 && !link_hit;

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        lock_d       = lock_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        is_ll_d      = is_ll_q;
        is_sc_d      = is_sc_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        result_d     = result_q;
        mem_stall    = 1'b0;
        wb_data_s4   = alu_out_s4;

        case (state_q)
            IDLE: begin
                if (sel_mem_s4) begin
                    mem_stall = 1'b1;
                    if (sc_fail) begin
                        // Failed SC completes locally without touching the bus.
                        state_d      = DONE;
                        result_d     = '0;
                        link_valid_d = 1'b0;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = mem_rw_s4;
                        lock_d  = atomic_s4;
                        addr_d  = word_addr;
                        wdata_d = store_lanes(r2_data_s4, byte_en_s4);
                        be_d    = byte_en_s4;
                        is_ll_d = load_link_s4 && !mem_rw_s4;
                        is_sc_d = check_link_s4 && mem_rw_s4;
                    end
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dmem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    lock_d  = 1'b0;
                    if (is_sc_q)   result_d = BITS'(1);
                    else if (we_q) result_d = alu_out_s4;
                    else           result_d = load_lanes(dmem_rdata, be_q);
                    if (is_ll_q) begin
                        link_valid_d = 1'b1;
                        link_addr_d  = addr_q;
                    end else if (we_q && (is_sc_q || addr_q == link_addr_q)) begin
                        link_valid_d = 1'b0;
                    end
                end
            end
            DONE: begin
                wb_data_s4 = result_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        halted_d = halted_q || (halt_s4 && !mem_stall);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            lock_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            is_ll_q      <= 1'b0;
            is_sc_q      <= 1'b0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            result_q     <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            lock_q       <= lock_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            is_ll_q      <= is_ll_d;
            is_sc_q      <= is_sc_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            result_q     <= result_d;
            halted_q     <= halted_d;
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_lock   = lock_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign dmem_be     = be_q;
    assign wb_rw_s4    = rw_s4 && !mem_stall;
    assign wb_waddr_s4 = waddr_s4;
    assign halted      = halted_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of memory ops against a small ack-delay bus responder,
// plus hand sequences for reset-in-flight and the sticky halt flag.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_;
    logic        sel_mem_s4, mem_rw_s4, load_link_s4, check_link_s4, atomic_s4, rw_s4, halt_s4;
    logic [4:0]  waddr_s4;
    logic [31:0] alu_out_s4, r2_data_s4;
    logic [3:0]  byte_en_s4;
    logic        dmem_req, dmem_we, dmem_lock, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, wb_rw_s4, halted;
    logic [31:0] wb_data_s4;
    logic [4:0]  wb_waddr_s4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_(rst_),
        .sel_mem_s4(sel_mem_s4), .mem_rw_s4(mem_rw_s4), .load_link_s4(load_link_s4),
        .check_link_s4(check_link_s4), .atomic_s4(atomic_s4), .rw_s4(rw_s4),
        .waddr_s4(waddr_s4), .alu_out_s4(alu_out_s4), .r2_data_s4(r2_data_s4),
        .byte_en_s4(byte_en_s4), .halt_s4(halt_s4),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_lock(dmem_lock),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .wb_data_s4(wb_data_s4), .wb_rw_s4(wb_rw_s4),
        .wb_waddr_s4(wb_waddr_s4), .halted(halted)
    );

    typedef struct {
        logic        sel, rw, ll, sc, atomic;
        logic [31:0] alu, r2, rdata;
        logic [3:0]  be;
        int          waits;
        int          exp_stall;
        logic        exp_req;
        logic [31:0] exp_addr, exp_wdata;
        logic        chk_wb;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sel, input logic rw, input logic ll, input logic sc,
                                input logic atomic, input logic [31:0] alu, input logic [31:0] r2,
                                input logic [3:0] be, input logic [31:0] rdata, input int waits,
                                input int exp_stall, input logic exp_req, input logic [31:0] exp_addr,
                                input logic [31:0] exp_wdata, input logic chk_wb,
                                input logic [31:0] exp_wb);
        vec_t v;
        v.sel = sel; v.rw = rw; v.ll = ll; v.sc = sc; v.atomic = atomic;
        v.alu = alu; v.r2 = r2; v.be = be; v.rdata = rdata; v.waits = waits;
        v.exp_stall = exp_stall; v.exp_req = exp_req; v.exp_addr = exp_addr;
        v.exp_wdata = exp_wdata; v.chk_wb = chk_wb; v.exp_wb = exp_wb;
        return v;
    endfunction

    // Starts in IDLE just after a negedge; ends one cycle after DONE with sel dropped.
    task automatic run_op(input vec_t v, input int idx);
        int stall = 0, wcnt = 0, guard = 0;
        logic seen = 1'b0;
        logic [31:0] c_addr = '0, c_wdata = '0;
        logic [3:0]  c_be = '0;
        logic        c_we = 1'b0, c_lock = 1'b0;
        string tag;
        tag = $sformatf("op%0d", idx);
        sel_mem_s4 = v.sel; mem_rw_s4 = v.rw; load_link_s4 = v.ll; check_link_s4 = v.sc;
        atomic_s4 = v.atomic; alu_out_s4 = v.alu; r2_data_s4 = v.r2; byte_en_s4 = v.be;
        dmem_rdata = v.rdata; rw_s4 = !v.rw || v.sc; waddr_s4 = 5'(idx); dmem_ack = 1'b0;
        #1;
        while (mem_stall && guard < 64) begin
            stall++; guard++;
            if (dmem_req) begin
                if (!seen) begin
                    c_addr = dmem_addr; c_wdata = dmem_wdata; c_be = dmem_be;
                    c_we = dmem_we; c_lock = dmem_lock;
                end
                seen = 1'b1;
                dmem_ack = (wcnt == v.waits);
                wcnt++;
            end else begin
                dmem_ack = 1'b0;
            end
            @(negedge clk); #1;
        end
        if (guard >= 64) begin
            errors++; checks++;
            $display("FAIL %s_timeout: stall never released", tag);
        end
        chk({tag, "_stall_cycles"}, 32'(stall), 32'(v.exp_stall));
        chk({tag, "_req_seen"}, {31'b0, seen}, {31'b0, v.exp_req});
        if (v.exp_req) begin
            chk({tag, "_addr"}, c_addr, v.exp_addr);
            chk({tag, "_we"}, {31'b0, c_we}, {31'b0, v.rw});
            chk({tag, "_be"}, {28'b0, c_be}, {28'b0, v.be});
            chk({tag, "_lock"}, {31'b0, c_lock}, {31'b0, v.atomic});
            if (v.rw) chk({tag, "_wdata"}, c_wdata, v.exp_wdata);
        end
        if (v.chk_wb) chk({tag, "_wb_data"}, wb_data_s4, v.exp_wb);
        chk({tag, "_wb_rw"}, {31'b0, wb_rw_s4}, {31'b0, rw_s4});
        chk({tag, "_wb_waddr"}, {27'b0, wb_waddr_s4}, {27'b0, 5'(idx)});
        @(negedge clk);
        sel_mem_s4 = 1'b0; dmem_ack = 1'b0;
        #1;
        chk({tag, "_no_reissue_stall"}, {31'b0, mem_stall}, 32'd0);
        chk({tag, "_no_reissue_req"}, {31'b0, dmem_req}, 32'd0);
    endtask

    initial begin
        rst_ = 1'b0; sel_mem_s4 = 1'b1; mem_rw_s4 = 1'b0; load_link_s4 = 1'b0;
        check_link_s4 = 1'b0; atomic_s4 = 1'b0; rw_s4 = 1'b1; halt_s4 = 1'b0;
        waddr_s4 = '0; alu_out_s4 = 32'h55; r2_data_s4 = '0; byte_en_s4 = 4'hF;
        dmem_ack = 1'b0; dmem_rdata = '0;

        //   sel rw ll sc at  alu           r2            be       rdata         w  st req addr          wdata        chk wb
        vecs.push_back(mk(0,0,0,0,0, 32'h1234,     32'h0,        4'b0000, 32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 32'h1234));
        vecs.push_back(mk(1,0,0,0,0, 32'h101,      32'h0,        4'b0010, 32'hAABBCCDD, 2, 4, 1, 32'h100, 32'h0,        1, 32'hCC));
        vecs.push_back(mk(1,1,0,0,0, 32'h202,      32'h0000BEEF, 4'b1100, 32'h0,        0, 2, 1, 32'h200, 32'hBEEFBEEF, 0, 32'h0));
        vecs.push_back(mk(1,0,0,0,0, 32'h300,      32'h0,        4'b1111, 32'h11223344, 1, 3, 1, 32'h300, 32'h0,        1, 32'h11223344));
        vecs.push_back(mk(1,0,0,0,0, 32'h302,      32'h0,        4'b1100, 32'hAABBCCDD, 0, 2, 1, 32'h300, 32'h0,        1, 32'hAABB));
        vecs.push_back(mk(1,0,0,0,0, 32'h300,      32'h0,        4'b0011, 32'hAABBCCDD, 0, 2, 1, 32'h300, 32'h0,        1, 32'hCCDD));
        vecs.push_back(mk(1,0,0,0,0, 32'h303,      32'h0,        4'b1000, 32'hAABBCCDD, 0, 2, 1, 32'h300, 32'h0,        1, 32'hAA));
        vecs.push_back(mk(1,0,0,0,0, 32'h300,      32'h0,        4'b0001, 32'hAABBCCDD, 0, 2, 1, 32'h300, 32'h0,        1, 32'hDD));
        vecs.push_back(mk(1,1,0,0,0, 32'h10,       32'h123456A5, 4'b0001, 32'h0,        0, 2, 1, 32'h10,  32'hA5A5A5A5, 0, 32'h0));
        vecs.push_back(mk(1,1,0,0,0, 32'h20,       32'hDEADBEEF, 4'b1111, 32'h0,        3, 5, 1, 32'h20,  32'hDEADBEEF, 0, 32'h0));
        // LL then SC succeeds, repeated SC fails without bus traffic
        vecs.push_back(mk(1,0,1,0,0, 32'h40,       32'h0,        4'b1111, 32'h5,        0, 2, 1, 32'h40,  32'h0,        1, 32'h5));
        vecs.push_back(mk(1,1,0,1,1, 32'h40,       32'h77,       4'b1111, 32'h0,        0, 2, 1, 32'h40,  32'h77,       1, 32'h1));
        vecs.push_back(mk(1,1,0,1,1, 32'h40,       32'h78,       4'b1111, 32'h0,        0, 1, 0, 32'h0,   32'h0,        1, 32'h0));
        // intervening store to the linked word breaks the link
        vecs.push_back(mk(1,0,1,0,0, 32'h40,       32'h0,        4'b1111, 32'h9,        0, 2, 1, 32'h40,  32'h0,        1, 32'h9));
        vecs.push_back(mk(1,1,0,0,0, 32'h40,       32'h1,        4'b1111, 32'h0,        0, 2, 1, 32'h40,  32'h1,        0, 32'h0));
        vecs.push_back(mk(1,1,0,1,0, 32'h40,       32'h2,        4'b1111, 32'h0,        0, 1, 0, 32'h0,   32'h0,        1, 32'h0));
        // store to another word leaves the link intact
        vecs.push_back(mk(1,0,1,0,0, 32'h40,       32'h0,        4'b1111, 32'h9,        0, 2, 1, 32'h40,  32'h0,        1, 32'h9));
        vecs.push_back(mk(1,1,0,0,0, 32'h44,       32'h2,        4'b1111, 32'h0,        0, 2, 1, 32'h44,  32'h2,        0, 32'h0));
        vecs.push_back(mk(1,1,0,1,0, 32'h40,       32'h3,        4'b1111, 32'h0,        1, 3, 1, 32'h40,  32'h3,        1, 32'h1));
        // SC to a different word than the link
        vecs.push_back(mk(1,0,1,0,0, 32'h80,       32'h0,        4'b1111, 32'hC,        0, 2, 1, 32'h80,  32'h0,        1, 32'hC));
        vecs.push_back(mk(1,1,0,1,0, 32'h84,       32'h4,        4'b1111, 32'h0,        0, 1, 0, 32'h0,   32'h0,        1, 32'h0));

        // Combinational outputs follow IDLE rules during reset.
        #1;
        chk("rst_stall_comb", {31'b0, mem_stall}, 32'd1);
        chk("rst_wb_data", wb_data_s4, 32'h55);
        sel_mem_s4 = 1'b0;
        #1;
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_we_lock", {30'b0, dmem_we, dmem_lock}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_be", {28'b0, dmem_be}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_stall_idle", {31'b0, mem_stall}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], i);

        // Reset while a locked LL-linked transaction is in REQ.
        run_op(mk(1,0,1,0,0, 32'h40, 32'h0, 4'b1111, 32'h1, 0, 2, 1, 32'h40, 32'h0, 1, 32'h1), 30);
        sel_mem_s4 = 1'b1; mem_rw_s4 = 1'b0; load_link_s4 = 1'b0; check_link_s4 = 1'b0;
        atomic_s4 = 1'b1; alu_out_s4 = 32'h100; byte_en_s4 = 4'hF; dmem_ack = 1'b0;
        @(negedge clk); #1;
        chk("abort_req_up", {31'b0, dmem_req}, 32'd1);
        chk("abort_lock_up", {31'b0, dmem_lock}, 32'd1);
        rst_ = 1'b0;
        #1;
        chk("abort_req_async", {31'b0, dmem_req}, 32'd0);
        chk("abort_lock_async", {31'b0, dmem_lock}, 32'd0);
        @(negedge clk);
        sel_mem_s4 = 1'b0; atomic_s4 = 1'b0; rst_ = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b1; alu_out_s4 = 32'h9999;
        #1;
        chk("late_ack_stall", {31'b0, mem_stall}, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
        chk("late_ack_stall2", {31'b0, mem_stall}, 32'd0);
        chk("late_ack_wb", wb_data_s4, 32'h9999);
        // Link was cleared by reset, so SC to the previously linked word fails.
        run_op(mk(1,1,0,1,0, 32'h40, 32'h5, 4'b1111, 32'h0, 0, 1, 0, 32'h0, 32'h0, 1, 32'h0), 31);

        // Halt is ignored while stalled, then sticks once seen unstalled.
        halt_s4 = 1'b1;
        sel_mem_s4 = 1'b1; mem_rw_s4 = 1'b0; load_link_s4 = 1'b0; check_link_s4 = 1'b0;
        alu_out_s4 = 32'h60; byte_en_s4 = 4'hF;
        @(negedge clk);
        halt_s4 = 1'b0;
        chk("halt_gated_by_stall", {31'b0, halted}, 32'd0);
        begin
            int g = 0;
            dmem_ack = 1'b1;
            #1;
            while (mem_stall && g < 16) begin
                @(negedge clk); #1; g++;
            end
            dmem_ack = 1'b0;
            chk("halt_op_done", {31'b0, mem_stall}, 32'd0);
        end
        @(negedge clk);
        sel_mem_s4 = 1'b0;
        chk("halt_still_clear", {31'b0, halted}, 32'd0);
        halt_s4 = 1'b1;
        @(negedge clk);
        halt_s4 = 1'b0;
        chk("halt_set", {31'b0, halted}, 32'd1);
        @(negedge clk); @(negedge clk);
        chk("halt_sticky", {31'b0, halted}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
